wbi_res_arb4: RTL and testbench

WBI_RES_ARB4 -- requirements
Module: wbi_res_arb4

---
 rtl/wbi_pkg.sv | 20 ++
 rtl/wbi_rr_pick4.sv | 39 +++
 rtl/wbi_res_arb4.sv | 137 +++++++++++++
 tb/tb_wbi_res_arb4.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbi_pkg.sv
// Definitions shared by the wbi response arbiter.
//   wbi_state_e : arbiter FSM states (IDLE = no grant, LOCK = grant held)
//   NS          : number of response sources (fixed at 4)
//   IDX_W       : width of a source index
//   next_idx()  : source index after i, wrapping 3 -> 0
package wbi_pkg;

    localparam int NS    = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } wbi_state_e;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/wbi_rr_pick4.sv
// Rotating priority encoder over 4 requests (purely combinational).
//   req   : request vector, one bit per source
//   start : index that gets the highest priority; priority falls with
//           increasing index and wraps 3 -> 0
//   idx   : index of the winning request (0 when nothing is requested)
//   valid : at least one request is set
module wbi_rr_pick4
    import wbi_pkg::*;
(
    input  logic [NS-1:0]    req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Rotate the requests so bit 0 is the source at 'start'; a plain
    // lowest-set-bit search then yields the offset from 'start'.
    logic [NS-1:0]    rot;
    logic [IDX_W-1:0] offset;

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_rot
            assign rot[gi] = req[start + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    assign valid = |rot;
    assign idx   = valid ? (start + offset) : '0;

endmodule

// File: rtl/wbi_res_arb4.sv
// Four-source response arbiter with burst lock.
// A source is granted round-robin and keeps the grant until it transfers
// a beat flagged lack or err; the next winner is then chosen in the same
// cycle so consecutive bursts hand over without a bubble.
//   mclk, reset_n        : clock, asynchronous active-low reset
//   src_rval_i/src_rrdy_o: per-source valid / ready (ready one-hot at most)
//   src_dat_i, src_ack_i, src_lack_i, src_err_i, src_tid_i : per-source fields
//   wbp_res_*            : merged response towards the consumer
//   wbp_res_rrdy_i       : consumer ready
//   gnt_o, busy_o        : current grant index, grant valid
module wbi_res_arb4 #(
    parameter int DW = 32,
    parameter int NS = 4
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic [NS-1:0]    src_rval_i,
    output logic [NS-1:0]    src_rrdy_o,
    input  logic [NS*DW-1:0] src_dat_i,
    input  logic [NS-1:0]    src_ack_i,
    input  logic [NS-1:0]    src_lack_i,
    input  logic [NS-1:0]    src_err_i,
    input  logic [NS*4-1:0]  src_tid_i,
    output logic             wbp_res_rval_o,
    output logic [DW-1:0]    wbp_res_dat_o,
    output logic             wbp_res_ack_o,
    output logic             wbp_res_lack_o,
    output logic             wbp_res_err_o,
    output logic [3:0]       wbp_res_tid_o,
    input  logic             wbp_res_rrdy_i,
    output logic [1:0]       gnt_o,
    output logic             busy_o
);

    import wbi_pkg::*;

    wbi_state_e       state_q;
    logic [IDX_W-1:0] gnt_q;
    logic [IDX_W-1:0] ptr_q;
    logic             busy_q;

    logic [DW-1:0]    dat_arr [NS];
    logic [3:0]       tid_arr [NS];

    logic             lock;
    logic             burst_end;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_split
            assign dat_arr[gi] = src_dat_i[gi*DW +: DW];
            assign tid_arr[gi] = src_tid_i[gi*4 +: 4];
        end
    endgenerate

    assign lock = (state_q == ST_LOCK);

    // Burst end: the granted source hands over a beat carrying lack or err.
    assign burst_end = lock && src_rval_i[gnt_q] && wbp_res_rrdy_i
                       && (src_lack_i[gnt_q] || src_err_i[gnt_q]);

    // One encoder serves both arbitration points: from ptr_q when idle,
    // from the source after the current grant when a burst ends. Starting
    // after gnt_q puts the finishing source last in line.
    assign pick_start = lock ? next_idx(gnt_q) : ptr_q;

    wbi_rr_pick4 u_pick (
        .req   (src_rval_i),
        .start (pick_start),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Response path is a pure mux on the registered grant; gating on the
    // state register makes reset clear the outputs without waiting a clock.
    always_comb begin
        wbp_res_rval_o = 1'b0;
        wbp_res_dat_o  = '0;
        wbp_res_ack_o  = 1'b0;
        wbp_res_lack_o = 1'b0;
        wbp_res_err_o  = 1'b0;
        wbp_res_tid_o  = '0;
        src_rrdy_o     = '0;
        if (lock) begin
            wbp_res_rval_o    = src_rval_i[gnt_q];
            wbp_res_dat_o     = dat_arr[gnt_q];
            wbp_res_ack_o     = src_ack_i[gnt_q];
            wbp_res_lack_o    = src_lack_i[gnt_q];
            wbp_res_err_o     = src_err_i[gnt_q];
            wbp_res_tid_o     = tid_arr[gnt_q];
            src_rrdy_o[gnt_q] = wbp_res_rrdy_i;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_LOCK;
                        gnt_q   <= pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    // Gaps in the granted source's valid do not release it.
                    if (burst_end) begin
                        ptr_q <= next_idx(gnt_q);
                        if (pick_valid) begin
                            gnt_q <= pick_idx;
                        end else begin
                            state_q <= ST_IDLE;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_wbi_res_arb4.sv
// Directed bench for wbi_res_arb4: each task drives one scenario and
// checks outputs against hand-computed values.
module tb_wbi_res_arb4;

    localparam int DW = 32;
    localparam int NS = 4;

    logic             mclk;
    logic             reset_n;
    logic [NS-1:0]    src_rval_i;
    logic [NS-1:0]    src_rrdy_o;
    logic [NS*DW-1:0] src_dat_i;
    logic [NS-1:0]    src_ack_i;
    logic [NS-1:0]    src_lack_i;
    logic [NS-1:0]    src_err_i;
    logic [NS*4-1:0]  src_tid_i;
    logic             wbp_res_rval_o;
    logic [DW-1:0]    wbp_res_dat_o;
    logic             wbp_res_ack_o;
    logic             wbp_res_lack_o;
    logic             wbp_res_err_o;
    logic [3:0]       wbp_res_tid_o;
    logic             wbp_res_rrdy_i;
    logic [1:0]       gnt_o;
    logic             busy_o;

    int vectors;
    int miscompares;

    wbi_res_arb4 #(.DW(DW), .NS(NS)) dut (
        .mclk           (mclk),
        .reset_n        (reset_n),
        .src_rval_i     (src_rval_i),
        .src_rrdy_o     (src_rrdy_o),
        .src_dat_i      (src_dat_i),
        .src_ack_i      (src_ack_i),
        .src_lack_i     (src_lack_i),
        .src_err_i      (src_err_i),
        .src_tid_i      (src_tid_i),
        .wbp_res_rval_o (wbp_res_rval_o),
        .wbp_res_dat_o  (wbp_res_dat_o),
        .wbp_res_ack_o  (wbp_res_ack_o),
        .wbp_res_lack_o (wbp_res_lack_o),
        .wbp_res_err_o  (wbp_res_err_o),
        .wbp_res_tid_o  (wbp_res_tid_o),
        .wbp_res_rrdy_i (wbp_res_rrdy_i),
        .gnt_o          (gnt_o),
        .busy_o         (busy_o)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Source s carries data 0xDA7A000s and tid 8+s; ack set on sources 0 and 2.
    function automatic logic [DW-1:0] exp_dat(input int s);
        return 32'hDA7A_0000 | DW'(s);
    endfunction

    function automatic logic [3:0] exp_tid(input int s);
        return 4'(8 + s);
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] rval, input logic [3:0] lack,
                          input logic [3:0] err, input logic rrdy);
        src_rval_i     = rval;
        src_lack_i     = lack;
        src_err_i      = err;
        wbp_res_rrdy_i = rrdy;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(posedge mclk);
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (busy_o !== 1'b0 || gnt_o !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b gnt=%0d, want busy=0 gnt=0", busy_o, gnt_o);
        end
        vectors++;
        if (wbp_res_rval_o !== 1'b0 || wbp_res_dat_o !== '0 || src_rrdy_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: rval=%b dat=%h rrdy=%b, want 0/0/0000",
                     wbp_res_rval_o, wbp_res_dat_o, src_rrdy_o);
        end
        $display("test_reset: busy=%b gnt=%0d", busy_o, gnt_o);
    endtask

    task automatic test_handover();
        apply_reset();
        set_in(4'b0110, 4'b0000, 4'b0000, 1'b0);
        #1;
        vectors++;
        if (busy_o !== 1'b0 || wbp_res_rval_o !== 1'b0) begin
            miscompares++;
            $display("FAIL handover_req_cycle: busy=%b rval=%b, want 0/0", busy_o, wbp_res_rval_o);
        end
        tick();
        vectors++;
        if (gnt_o !== 2'd1 || busy_o !== 1'b1 || wbp_res_rval_o !== 1'b1
            || wbp_res_dat_o !== exp_dat(1) || wbp_res_tid_o !== exp_tid(1)) begin
            miscompares++;
            $display("FAIL handover_first: gnt=%0d busy=%b rval=%b dat=%h tid=%h, want 1/1/1/%h/%h",
                     gnt_o, busy_o, wbp_res_rval_o, wbp_res_dat_o, wbp_res_tid_o, exp_dat(1), exp_tid(1));
        end
        set_in(4'b0110, 4'b0010, 4'b0000, 1'b1);
        #1;
        vectors++;
        if (src_rrdy_o !== 4'b0010 || wbp_res_ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL handover_rrdy: rrdy=%b ack=%b, want 0010/0", src_rrdy_o, wbp_res_ack_o);
        end
        tick();
        set_in(4'b0100, 4'b0000, 4'b0000, 1'b1);
        #1;
        vectors++;
        if (gnt_o !== 2'd2 || busy_o !== 1'b1 || wbp_res_rval_o !== 1'b1
            || wbp_res_dat_o !== exp_dat(2) || src_rrdy_o !== 4'b0100 || wbp_res_ack_o !== 1'b1) begin
            miscompares++;
            $display("FAIL handover_second: gnt=%0d busy=%b rval=%b dat=%h rrdy=%b ack=%b, want 2/1/1/%h/0100/1",
                     gnt_o, busy_o, wbp_res_rval_o, wbp_res_dat_o, src_rrdy_o, wbp_res_ack_o, exp_dat(2));
        end
        $display("test_handover: gnt=%0d busy=%b", gnt_o, busy_o);
    endtask

    task automatic test_burst_gap();
        logic [5:0] pat;
        logic       r0;
        apply_reset();
        pat = 6'b110011;
        set_in(4'b0011, 4'b0000, 4'b0000, 1'b1);
        tick();
        for (int c = 0; c < 6; c++) begin
            r0 = pat[c];
            set_in({3'b001, r0}, (c == 5) ? 4'b0001 : 4'b0000, 4'b0000, 1'b1);
            #1;
            vectors++;
            if (gnt_o !== 2'd0 || wbp_res_rval_o !== r0 || busy_o !== 1'b1) begin
                miscompares++;
                $display("FAIL burst_hold c%0d: gnt=%0d rval=%b busy=%b, want 0/%b/1",
                         c, gnt_o, wbp_res_rval_o, busy_o, r0);
            end
            tick();
        end
        vectors++;
        if (gnt_o !== 2'd1 || busy_o !== 1'b1 || wbp_res_dat_o !== exp_dat(1)) begin
            miscompares++;
            $display("FAIL burst_next: gnt=%0d busy=%b dat=%h, want 1/1/%h",
                     gnt_o, busy_o, wbp_res_dat_o, exp_dat(1));
        end
        $display("test_burst_gap: final gnt=%0d", gnt_o);
    endtask

    task automatic test_rotation();
        logic [1:0] eg;
        apply_reset();
        set_in(4'b1111, 4'b1111, 4'b0000, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            eg = 2'(k % 4);
            vectors++;
            if (gnt_o !== eg || src_rrdy_o !== (4'b0001 << eg) || wbp_res_dat_o !== exp_dat(int'(eg))) begin
                miscompares++;
                $display("FAIL rotation k%0d: gnt=%0d rrdy=%b dat=%h, want %0d/%b/%h",
                         k, gnt_o, src_rrdy_o, wbp_res_dat_o, eg, 4'b0001 << eg, exp_dat(int'(eg)));
            end
            $display("test_rotation: k=%0d gnt=%0d rrdy=%b", k, gnt_o, src_rrdy_o);
            tick();
        end
    endtask

    task automatic test_err_end();
        apply_reset();
        set_in(4'b0100, 4'b0000, 4'b0000, 1'b1);
        tick();
        set_in(4'b1110, 4'b0000, 4'b0100, 1'b1);
        #1;
        vectors++;
        if (gnt_o !== 2'd2 || wbp_res_err_o !== 1'b1 || wbp_res_lack_o !== 1'b0
            || wbp_res_tid_o !== exp_tid(2)) begin
            miscompares++;
            $display("FAIL err_beat: gnt=%0d err=%b lack=%b tid=%h, want 2/1/0/%h",
                     gnt_o, wbp_res_err_o, wbp_res_lack_o, wbp_res_tid_o, exp_tid(2));
        end
        tick();
        vectors++;
        if (gnt_o !== 2'd3 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL err_next: gnt=%0d busy=%b, want 3/1", gnt_o, busy_o);
        end
        set_in(4'b1110, 4'b1000, 4'b0000, 1'b1);
        tick();
        vectors++;
        if (gnt_o !== 2'd1 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL err_wrap: gnt=%0d busy=%b, want 1/1", gnt_o, busy_o);
        end
        $display("test_err_end: gnt=%0d", gnt_o);
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        set_in(4'b1000, 4'b0000, 4'b0000, 1'b1);
        tick();
        tick();
        vectors++;
        if (gnt_o !== 2'd3 || busy_o !== 1'b1 || wbp_res_rval_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_locked: gnt=%0d busy=%b rval=%b, want 3/1/1",
                     gnt_o, busy_o, wbp_res_rval_o);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 1'b0 || gnt_o !== 2'd0 || wbp_res_rval_o !== 1'b0
            || wbp_res_dat_o !== '0 || wbp_res_tid_o !== 4'd0 || src_rrdy_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_clear: busy=%b gnt=%0d rval=%b dat=%h tid=%h rrdy=%b, want all 0",
                     busy_o, gnt_o, wbp_res_rval_o, wbp_res_dat_o, wbp_res_tid_o, src_rrdy_o);
        end
        #2;
        reset_n = 1'b1;
        tick();
        vectors++;
        if (gnt_o !== 2'd3 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_regrant: gnt=%0d busy=%b, want 3/1", gnt_o, busy_o);
        end
        $display("test_reset_mid_burst: gnt=%0d busy=%b", gnt_o, busy_o);
    endtask

    task automatic test_stall();
        apply_reset();
        set_in(4'b0011, 4'b0001, 4'b0000, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (gnt_o !== 2'd0 || wbp_res_rval_o !== 1'b1 || wbp_res_lack_o !== 1'b1
                || wbp_res_dat_o !== exp_dat(0) || src_rrdy_o !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall c%0d: gnt=%0d rval=%b lack=%b dat=%h rrdy=%b, want 0/1/1/%h/0000",
                         c, gnt_o, wbp_res_rval_o, wbp_res_lack_o, wbp_res_dat_o, src_rrdy_o, exp_dat(0));
            end
            tick();
        end
        wbp_res_rrdy_i = 1'b1;
        tick();
        vectors++;
        if (gnt_o !== 2'd1 || wbp_res_dat_o !== exp_dat(1)) begin
            miscompares++;
            $display("FAIL stall_release: gnt=%0d dat=%h, want 1/%h", gnt_o, wbp_res_dat_o, exp_dat(1));
        end
        $display("test_stall: gnt=%0d", gnt_o);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        src_dat_i   = {exp_dat(3), exp_dat(2), exp_dat(1), exp_dat(0)};
        src_tid_i   = {exp_tid(3), exp_tid(2), exp_tid(1), exp_tid(0)};
        src_ack_i   = 4'b0101;
        set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);

        test_reset();
        test_handover();
        test_burst_gap();
        test_rotation();
        test_err_end();
        test_reset_mid_burst();
        test_stall();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
